// File: rtl/streamer_csr_sequencer.sv
// streamer_csr_sequencer
//   Hardware CSR launcher for the streamer wrapper. On launch it snapshots the
//   configuration vector and writes it to CSR addresses 0..NumCfgRegs-1. When
//   Verify is set, it then reads each register back and compares it with the
//   snapshot. Finally it writes 1 to the start register at StartAddr.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   launch_i                launch request, only honoured while idle
//   cfg_data_i              packed config, reg k at [k*CsrDW +: CsrDW]
//   busy_o                  sequencer not idle
//   done_o                  one-cycle pulse after the start write handshakes
//   err_o, err_addr_o       sticky read-back mismatch flag and its address
//   io_csr_req_*            CSR request channel (valid/ready)
//   io_csr_rsp_*            CSR read response channel (ready tied high)
module streamer_csr_sequencer #(
  parameter int unsigned NumCfgRegs = 13,
  parameter int unsigned StartAddr  = 13,
  parameter int unsigned CsrDW      = 32,
  parameter bit          Verify     = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        launch_i,
  input  logic [NumCfgRegs*CsrDW-1:0] cfg_data_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [CsrDW-1:0]            err_addr_o,
  output logic [CsrDW-1:0]            io_csr_req_bits_data_o,
  output logic [CsrDW-1:0]            io_csr_req_bits_addr_o,
  output logic                        io_csr_req_bits_write_o,
  output logic                        io_csr_req_valid_o,
  input  logic                        io_csr_req_ready_i,
  input  logic                        io_csr_rsp_valid_i,
  input  logic [CsrDW-1:0]            io_csr_rsp_bits_data_i,
  output logic                        io_csr_rsp_ready_o
);

  localparam int unsigned     IdxW    = $clog2(NumCfgRegs + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCfgRegs - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_RSP,
    GO,
    ERR
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               err_q, err_d;
  logic [CsrDW-1:0]   err_addr_q, err_addr_d;
  logic               done_q, done_d;
  logic [CsrDW-1:0]   snap_q [NumCfgRegs];
  logic               snap_en;
  logic [CsrDW-1:0]   snap_cur;
  logic               req_hs;

  assign snap_cur = snap_q[idx_q];
  assign req_hs   = io_csr_req_valid_o & io_csr_req_ready_i;

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
    end
  end

  // Config snapshot; needs no reset since it is always reloaded before use
  always_ff @(posedge clk_i) begin
    if (snap_en && !rst_i) begin
      for (int unsigned k = 0; k < NumCfgRegs; k++) begin
        snap_q[k] <= cfg_data_i[k*CsrDW +: CsrDW];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    done_d     = 1'b0;
    snap_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch_i) begin
          snap_en    = 1'b1;
          err_d      = 1'b0;
          err_addr_d = '0;
          idx_d      = '0;
          state_d    = WR;
        end
      end
      WR: begin
        if (req_hs) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = Verify ? RD_REQ : GO;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (req_hs) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (io_csr_rsp_valid_i) begin
          if (io_csr_rsp_bits_data_i != snap_cur) begin
            err_d      = 1'b1;
            err_addr_d = CsrDW'(idx_q);
            state_d    = ERR;
          end else if (idx_q == LastIdx) begin
            state_d = GO;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      GO: begin
        if (req_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request fields are pure functions of state/idx, so they stay
  // stable for as long as the state waits on ready.
  always_comb begin
    io_csr_req_valid_o      = 1'b0;
    io_csr_req_bits_write_o = 1'b0;
    io_csr_req_bits_addr_o  = '0;
    io_csr_req_bits_data_o  = '0;
    unique case (state_q)
      WR: begin
        io_csr_req_valid_o      = 1'b1;
        io_csr_req_bits_write_o = 1'b1;
        io_csr_req_bits_addr_o  = CsrDW'(idx_q);
        io_csr_req_bits_data_o  = snap_cur;
      end
      RD_REQ: begin
        io_csr_req_valid_o     = 1'b1;
        io_csr_req_bits_addr_o = CsrDW'(idx_q);
      end
      GO: begin
        io_csr_req_valid_o      = 1'b1;
        io_csr_req_bits_write_o = 1'b1;
        io_csr_req_bits_addr_o  = CsrDW'(StartAddr);
        io_csr_req_bits_data_o  = CsrDW'(1);
      end
      default: ;
    endcase
  end

  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign err_o              = err_q;
  assign err_addr_o         = err_addr_q;
  assign io_csr_rsp_ready_o = 1'b1;

endmodule

// File: tb/tb_streamer_csr_sequencer.sv
module tb_streamer_csr_sequencer;

  localparam int N  = 13;
  localparam int DW = 32;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                launch = 1'b0;
  logic [N*DW-1:0]     cfg = '0;
  logic                busy, done, err;
  logic [DW-1:0]       err_addr, req_data, req_addr, rsp_data = '0;
  logic                req_write, req_valid, ready = 1'b0, rsp_valid = 1'b0, rsp_ready;

  logic                launch_n = 1'b0, ready_n = 1'b0, rsp_valid_n = 1'b0;
  logic [DW-1:0]       rsp_data_n = '0;
  logic                busy_n, done_n, err_n, req_write_n, req_valid_n, rsp_ready_n;
  logic [DW-1:0]       err_addr_n, req_data_n, req_addr_n;

  streamer_csr_sequencer #(.NumCfgRegs(N), .StartAddr(13), .CsrDW(DW), .Verify(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .launch_i(launch), .cfg_data_i(cfg),
    .busy_o(busy), .done_o(done), .err_o(err), .err_addr_o(err_addr),
    .io_csr_req_bits_data_o(req_data), .io_csr_req_bits_addr_o(req_addr),
    .io_csr_req_bits_write_o(req_write), .io_csr_req_valid_o(req_valid),
    .io_csr_req_ready_i(ready), .io_csr_rsp_valid_i(rsp_valid),
    .io_csr_rsp_bits_data_i(rsp_data), .io_csr_rsp_ready_o(rsp_ready)
  );

  streamer_csr_sequencer #(.NumCfgRegs(N), .StartAddr(13), .CsrDW(DW), .Verify(1'b0)) dut_nv (
    .clk_i(clk), .rst_i(rst), .launch_i(launch_n), .cfg_data_i(cfg),
    .busy_o(busy_n), .done_o(done_n), .err_o(err_n), .err_addr_o(err_addr_n),
    .io_csr_req_bits_data_o(req_data_n), .io_csr_req_bits_addr_o(req_addr_n),
    .io_csr_req_bits_write_o(req_write_n), .io_csr_req_valid_o(req_valid_n),
    .io_csr_req_ready_i(ready_n), .io_csr_rsp_valid_i(rsp_valid_n),
    .io_csr_rsp_bits_data_i(rsp_data_n), .io_csr_rsp_ready_o(rsp_ready_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  req_t        sb[$];
  req_t        sbn[$];
  logic [31:0] cfg_vals [N];
  logic [31:0] snap_exp [N];
  logic [31:0] mem [16];

  int cyc = 0, cyc_launch = 0, first_req_at = -1, done_cnt = 0, done_at = -1;
  int stall_n = 0, stall_cnt = 0, rst_at_addr = -1, corrupt_addr = -1;
  bit launch_req = 0, rsp_pend = 0, hold_valid = 0;
  logic [31:0] rsp_pend_data, held_addr, held_data;
  logic        held_write;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < N; k++) cfg[k*DW +: DW] = cfg_vals[k];
  endtask

  task automatic push_seq(input int n_reads, input bit with_start);
    req_t r;
    for (int k = 0; k < N; k++) begin
      r.w = 1'b1; r.a = 32'(k); r.d = snap_exp[k]; sb.push_back(r);
    end
    for (int k = 0; k < n_reads; k++) begin
      r.w = 1'b0; r.a = 32'(k); r.d = '0; sb.push_back(r);
    end
    if (with_start) begin
      r.w = 1'b1; r.a = 32'd13; r.d = 32'd1; sb.push_back(r);
    end
  endtask

  task automatic do_launch(input bit accept, input int n_reads, input bit with_start);
    launch_req = 1'b1;
    if (accept) begin
      for (int k = 0; k < N; k++) snap_exp[k] = cfg_vals[k];
      push_seq(n_reads, with_start);
      cyc_launch   = cyc + 1;
      first_req_at = -1;
      done_cnt     = 0;
      done_at      = -1;
    end
  endtask

  // One clock of the Verify=1 DUT: CSR slave model plus scoreboard pop on handshake
  task automatic cycle();
    req_t e;
    @(negedge clk);
    cyc++;
    rst        = 1'b0;
    launch     = launch_req;
    launch_req = 1'b0;
    rsp_valid  = rsp_pend;
    rsp_data   = rsp_pend_data;
    rsp_pend   = 1'b0;
    if (done) begin
      done_cnt++;
      done_at = cyc - cyc_launch;
    end
    if (hold_valid) begin
      check_val("valid_held", 64'(req_valid), 1);
      check_val("addr_held", 64'(req_addr), 64'(held_addr));
      check_val("data_held", 64'(req_data), 64'(held_data));
      check_val("write_held", 64'(req_write), 64'(held_write));
    end
    hold_valid = 1'b0;
    if (req_valid && first_req_at < 0) first_req_at = cyc - cyc_launch;
    if (rst_at_addr >= 0 && req_valid && req_write && req_addr == 32'(rst_at_addr)) begin
      rst         = 1'b1;
      ready       = 1'b0;
      rst_at_addr = -1;
      sb.delete();
      stall_cnt   = 0;
    end else if (req_valid) begin
      ready = (stall_cnt >= stall_n);
      if (ready) begin
        stall_cnt = 0;
        check_val("req_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("req_write", 64'(req_write), 64'(e.w));
          check_val("req_addr", 64'(req_addr), 64'(e.a));
          check_val("req_data", 64'(req_data), 64'(e.d));
        end
        if (req_write) mem[req_addr[3:0]] = req_data;
        else begin
          rsp_pend      = 1'b1;
          rsp_pend_data = (req_addr == 32'(corrupt_addr)) ? 32'd5 : mem[req_addr[3:0]];
        end
      end else begin
        stall_cnt++;
        hold_valid = 1'b1;
        held_addr  = req_addr;
        held_data  = req_data;
        held_write = req_write;
      end
    end else begin
      ready = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit fin = 0;
    for (int i = 0; i < max_cyc && !fin; i++) begin
      cycle();
      if (i > 0 && !busy) fin = 1;
    end
    check_val("idle_reached", 64'(fin), 1);
  endtask

  initial begin
    req_t e;
    bit fin;
    int dn_cnt, dn_at, lcyc;

    for (int k = 0; k < 16; k++) mem[k] = '0;
    cfg_vals = '{32'd10, 32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4, 32'd4,
                 32'd0, 32'd0, 32'd0, 32'd0};
    apply_cfg();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_done", 64'(done), 0);
    check_val("rst_err", 64'(err), 0);
    check_val("rst_err_addr", 64'(err_addr), 0);
    check_val("rst_valid", 64'(req_valid), 0);
    check_val("rst_addr", 64'(req_addr), 0);
    check_val("rst_data", 64'(req_data), 0);
    check_val("rst_write", 64'(req_write), 0);
    check_val("rst_rsp_ready", 64'(rsp_ready), 1);

    // 1: basic launch with read-back
    cycle();
    do_launch(1, N, 1);
    wait_idle(100);
    check_val("t1_first_req", 64'(first_req_at), 1);
    check_val("t1_done_at", 64'(done_at), 41);
    check_val("t1_done_cnt", 64'(done_cnt), 1);
    check_val("t1_err", 64'(err), 0);
    check_val("t1_sb_empty", 64'(sb.size()), 0);
    repeat (2) cycle();
    check_val("t1_done_pulse", 64'(done_cnt), 1);

    // 2: backpressure, 3 stall cycles per request
    stall_n = 3;
    for (int k = 0; k < N; k++) cfg_vals[k] = $urandom;
    apply_cfg();
    do_launch(1, N, 1);
    wait_idle(400);
    check_val("t2_done_cnt", 64'(done_cnt), 1);
    check_val("t2_err", 64'(err), 0);
    check_val("t2_sb_empty", 64'(sb.size()), 0);
    stall_n = 0;

    // 3: read-back corruption at addr 6, then a clean relaunch clears err
    cfg_vals = '{32'd10, 32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4, 32'd4,
                 32'd0, 32'd0, 32'd0, 32'd0};
    apply_cfg();
    corrupt_addr = 6;
    do_launch(1, 7, 0);
    wait_idle(100);
    repeat (3) cycle();
    check_val("t3_err", 64'(err), 1);
    check_val("t3_err_addr", 64'(err_addr), 6);
    check_val("t3_done_cnt", 64'(done_cnt), 0);
    check_val("t3_sb_empty", 64'(sb.size()), 0);
    check_val("t3_busy", 64'(busy), 0);
    corrupt_addr = -1;
    do_launch(1, N, 1);
    cycle();
    cycle();
    check_val("t3_err_cleared", 64'(err), 0);
    check_val("t3_err_addr_cleared", 64'(err_addr), 0);
    wait_idle(100);
    check_val("t3b_done_cnt", 64'(done_cnt), 1);
    check_val("t3b_err", 64'(err), 0);

    // 4: launch while busy is ignored; cfg change after launch has no effect
    for (int k = 0; k < N; k++) cfg_vals[k] = 32'h100 + 32'(k);
    apply_cfg();
    do_launch(1, N, 1);
    repeat (5) cycle();
    do_launch(0, 0, 0);
    for (int k = 0; k < N; k++) cfg_vals[k] = 32'hdead0000 + 32'(k);
    apply_cfg();
    wait_idle(100);
    check_val("t4_done_at", 64'(done_at), 41);
    check_val("t4_done_cnt", 64'(done_cnt), 1);
    repeat (4) cycle();
    check_val("t4_still_idle", 64'(busy), 0);
    check_val("t4_sb_empty", 64'(sb.size()), 0);

    // 5: reset while writing addr 4, then relaunch from addr 0
    rst_at_addr = 4;
    do_launch(1, N, 1);
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      cycle();
      if (rst_at_addr < 0) fin = 1;
    end
    check_val("t5_rst_hit", 64'(fin), 1);
    cycle();
    check_val("t5_valid_dropped", 64'(req_valid), 0);
    check_val("t5_busy", 64'(busy), 0);
    check_val("t5_no_done", 64'(done_cnt), 0);
    repeat (2) cycle();
    do_launch(1, N, 1);
    wait_idle(100);
    check_val("t5_done_at", 64'(done_at), 41);
    check_val("t5_done_cnt", 64'(done_cnt), 1);
    check_val("t5_sb_empty", 64'(sb.size()), 0);

    // 6: Verify=0 instance, with a spurious response pulse
    for (int k = 0; k < N; k++) begin
      e.w = 1'b1; e.a = 32'(k); e.d = cfg_vals[k]; sbn.push_back(e);
    end
    e.w = 1'b1; e.a = 32'd13; e.d = 32'd1; sbn.push_back(e);
    @(negedge clk);
    cyc++;
    launch_n = 1'b1;
    ready_n  = 1'b1;
    lcyc     = cyc;
    dn_cnt   = 0;
    dn_at    = -1;
    fin      = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      cyc++;
      launch_n    = 1'b0;
      rsp_valid_n = (i == 4);
      rsp_data_n  = 32'hbad0bad0;
      if (done_n) begin
        dn_cnt++;
        dn_at = cyc - lcyc;
      end
      if (req_valid_n) begin
        check_val("nv_req_expected", 64'(sbn.size() != 0), 1);
        if (sbn.size() != 0) begin
          e = sbn.pop_front();
          check_val("nv_req_write", 64'(req_write_n), 64'(e.w));
          check_val("nv_req_addr", 64'(req_addr_n), 64'(e.a));
          check_val("nv_req_data", 64'(req_data_n), 64'(e.d));
        end
      end
      if (i > 0 && !busy_n) fin = 1;
    end
    rsp_valid_n = 1'b0;
    check_val("nv_idle_reached", 64'(fin), 1);
    check_val("nv_done_at", 64'(dn_at), 15);
    check_val("nv_done_cnt", 64'(dn_cnt), 1);
    check_val("nv_err", 64'(err_n), 0);
    check_val("nv_sb_empty", 64'(sbn.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
